// File: rtl/tcn_fifo_reader.sv
// Read-side walker for the TCN activation window: issues physical reads oldest-block-first and
// streams the returned words over valid/ready. Define TCN_FIFO_DECODE_EN to add the phys->logical decoder.
module tcn_fifo_reader #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              FIFO_TCN_active,
    input  logic [ADDR_W-1:0] FIFO_TCN_block_size,
    input  logic [ADDR_W-1:0] FIFO_TCN_total_blocks,
    input  logic              FIFO_TCN_update_pointer,
    input  logic              start,
    output logic              mem_rd_enable,
    output logic [ADDR_W-1:0] mem_rd_address,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
`ifdef TCN_FIFO_DECODE_EN
    ,
    input  logic [ADDR_W-1:0] phys_address_in,
    output logic [ADDR_W-1:0] logical_address_out
`endif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_READ   = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [ADDR_W-1:0] total_size;
    logic [ADDR_W-1:0] base;
    logic              upd_q;
    logic [ADDR_W:0]   base_sum;

    logic [1:0]        state, state_next;
    logic [ADDR_W-1:0] base_s, tot_s, lc;
    logic [ADDR_W:0]   rd_sum;

    logic [1:0]        count;
    logic              wr_ptr, rd_ptr;
    logic              inflight_q, inflight_last_q;
    logic [DATA_W-1:0] fifo_data [2];
    logic              fifo_last [2];

    logic              pop, issue, last_issue, credit, drain_done;
    logic [2:0]        occupancy;

    assign total_size = FIFO_TCN_total_blocks * FIFO_TCN_block_size;
    assign base_sum   = {1'b0, base} + {1'b0, FIFO_TCN_block_size};

    // Live base pointer; must advance exactly like the encoder's copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_q <= 1'b0;
            base  <= '0;
        end else begin
            upd_q <= FIFO_TCN_update_pointer;
            if (upd_q) begin
                base <= (base_sum >= {1'b0, total_size}) ? '0 : ADDR_W'(base_sum);
            end
        end
    end

    // A word leaving this cycle frees its slot immediately, which keeps one read per cycle with two entries.
    assign out_valid  = (count != 2'd0);
    assign pop        = out_valid & out_ready;
    assign occupancy  = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    assign credit     = (occupancy < 3'd2);
    assign issue      = (state == S_READ) && credit;
    assign last_issue = (lc == tot_s - ADDR_W'(1));
    assign drain_done = !inflight_q && ((count == 2'd0) || ((count == 2'd1) && pop));

    assign rd_sum         = {1'b0, lc} + {1'b0, base_s};
    assign mem_rd_enable  = issue;
    assign mem_rd_address = (rd_sum >= {1'b0, tot_s}) ? ADDR_W'(rd_sum - {1'b0, tot_s})
                                                      : ADDR_W'(rd_sum);

    assign out_data = out_valid ? fifo_data[rd_ptr] : '0;
    assign out_last = out_valid & fifo_last[rd_ptr];
    assign busy     = (state == S_READ) || (state == S_DRAIN);
    assign done     = (state == S_FINISH);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = (total_size == '0) ? S_FINISH : S_READ;
            S_READ:   if (issue && last_issue) state_next = S_DRAIN;
            S_DRAIN:  if (drain_done) state_next = S_FINISH;
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            base_s          <= '0;
            tot_s           <= '0;
            lc              <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            count           <= 2'd0;
            wr_ptr          <= 1'b0;
            rd_ptr          <= 1'b0;
        end else begin
            state <= state_next;
            if ((state == S_IDLE) && start) begin
                base_s <= FIFO_TCN_active ? base : '0;
                tot_s  <= total_size;
                lc     <= '0;
            end else if (issue) begin
                lc <= lc + ADDR_W'(1);
            end
            inflight_q      <= issue;
            inflight_last_q <= issue && last_issue;
            if (inflight_q) wr_ptr <= ~wr_ptr;
            if (pop)        rd_ptr <= ~rd_ptr;
            case ({inflight_q, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

    // NOTE: buffer storage has no reset; out_data/out_last are masked by out_valid so stale entries never escape.
    always_ff @(posedge clk) begin
        if (inflight_q) begin
            fifo_data[wr_ptr] <= mem_rd_data;
            fifo_last[wr_ptr] <= inflight_last_q;
        end
    end

`ifdef TCN_FIFO_DECODE_EN
    logic [ADDR_W-1:0] live_base;
    logic [ADDR_W:0]   dec_wrap;

    assign live_base = FIFO_TCN_active ? base : '0;
    assign dec_wrap  = {1'b0, phys_address_in} + {1'b0, total_size} - {1'b0, live_base};

    always_comb begin
        if (phys_address_in >= total_size) begin
            logical_address_out = phys_address_in;
        end else if (phys_address_in >= live_base) begin
            logical_address_out = phys_address_in - live_base;
        end else begin
            logical_address_out = ADDR_W'(dec_wrap);
        end
    end
`endif

endmodule

// File: tb/tb_tcn_fifo_reader.sv
// Self-checking bench for tcn_fifo_reader: randomized backpressure and data against a modulo-arithmetic
// window model; decode checks are compiled only when TCN_FIFO_DECODE_EN is defined.
module tb_tcn_fifo_reader;

    localparam int AW = 16;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          active;
    logic [AW-1:0] blk_size;
    logic [AW-1:0] tot_blocks;
    logic          update;
    logic          start;
    logic          mem_rd_enable;
    logic [AW-1:0] mem_rd_address;
    logic [DW-1:0] mem_rd_data = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;
`ifdef TCN_FIFO_DECODE_EN
    logic [AW-1:0] phys_in;
    logic [AW-1:0] logical_out;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int m_base = 0;
    logic [31:0] salt = 32'h1234_5678;

    // Monitor records
    logic [AW-1:0] rd_q[$];
    logic [DW-1:0] dq[$];
    logic          lq[$];
    int start_cyc, first_busy_cyc, first_rd_cyc, first_val_cyc, hs_last_cyc, done_cyc;
    int done_cnt, issued, accepted, viol;
    logic done_busy;

    tcn_fifo_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .FIFO_TCN_active        (active),
        .FIFO_TCN_block_size    (blk_size),
        .FIFO_TCN_total_blocks  (tot_blocks),
        .FIFO_TCN_update_pointer(update),
        .start                  (start),
        .mem_rd_enable          (mem_rd_enable),
        .mem_rd_address         (mem_rd_address),
        .mem_rd_data            (mem_rd_data),
        .out_data               (out_data),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .out_last               (out_last),
        .busy                   (busy),
        .done                   (done)
`ifdef TCN_FIFO_DECODE_EN
        ,
        .phys_address_in        (phys_in),
        .logical_address_out    (logical_out)
`endif
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {salt, ~a, a};
    endfunction

    function automatic int m_total();
        return (int'(tot_blocks) * int'(blk_size)) % 65536;
    endfunction

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Activation memory: word appears one cycle after the strobe
    always @(posedge clk) mem_rd_data <= mem_rd_enable ? mem_word(mem_rd_address) : '0;

    always @(negedge clk) begin
        if (!reset) begin
            if (start) start_cyc = cyc;
            if (busy && first_busy_cyc < 0) first_busy_cyc = cyc;
            if (mem_rd_enable) begin
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                if (issued - accepted - ((out_valid && out_ready) ? 1 : 0) >= 2) viol++;
                rd_q.push_back(mem_rd_address);
                issued++;
            end
            if (out_valid && first_val_cyc < 0) first_val_cyc = cyc;
            if (out_valid && out_ready) begin
                dq.push_back(out_data);
                lq.push_back(out_last);
                accepted++;
                if (out_last) hs_last_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc  = cyc;
                done_busy = busy;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rd_q.delete();
        dq.delete();
        lq.delete();
        start_cyc = -1; first_busy_cyc = -1; first_rd_cyc = -1; first_val_cyc = -1;
        hs_last_cyc = -1; done_cyc = -1; done_cnt = 0; issued = 0; accepted = 0; viol = 0;
        done_busy = 1'b0;
    endtask

    task automatic model_advance();
        if (m_base + int'(blk_size) >= m_total()) m_base = 0;
        else m_base = m_base + int'(blk_size);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_base = 0;
        step();
    endtask

    task automatic pulse_update(input int n);
        for (int i = 0; i < n; i++) begin
            update = 1'b1;
            step();
            update = 1'b0;
            model_advance();
            step();
            step();
        end
    endtask

    task automatic run_readout(input string name, input int ready_mode, input int upd_at,
                               input bit check_timing);
        int base_s, tot, k, ev;
        logic [AW-1:0] ea;
        tot    = m_total();
        base_s = active ? m_base : 0;
        salt   = $urandom;
        clear_mon();
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (done_cnt == 0 && k < 400) begin
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((k % 3) == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            update = (k == upd_at);
            step();
            if (update) begin
                update = 1'b0;
                model_advance();
            end
            k++;
        end
        out_ready = 1'b1;
        step();
        step();

        total++;
        if (done_cnt !== 1) begin
            bad++;
            $display("FAIL %s done_count: got %0d want 1", name, done_cnt);
        end
        total++;
        if (rd_q.size() != tot || dq.size() != tot) begin
            bad++;
            $display("FAIL %s counts: reads %0d words %0d want %0d", name, rd_q.size(), dq.size(), tot);
        end else begin
            for (int i = 0; i < tot; i++) begin
                ev = (base_s + i) % tot;
                ea = ev[AW-1:0];
                total++;
                if (rd_q[i] !== ea) begin
                    bad++;
                    $display("FAIL %s addr[%0d]: got %0h want %0h", name, i, rd_q[i], ea);
                end
                total++;
                if (dq[i] !== mem_word(ea) || lq[i] !== (i == tot - 1)) begin
                    bad++;
                    $display("FAIL %s word[%0d]: got %0h/%0b want %0h/%0b", name, i, dq[i], lq[i],
                             mem_word(ea), (i == tot - 1));
                end
            end
        end
        total++;
        if (tot > 0 && (done_cyc !== hs_last_cyc + 1 || done_busy !== 1'b0)) begin
            bad++;
            $display("FAIL %s done_timing: done@%0d busy=%0b last_hs@%0d", name, done_cyc, done_busy,
                     hs_last_cyc);
        end else if (tot == 0 && done_cyc !== start_cyc + 1) begin
            bad++;
            $display("FAIL %s empty_done: done@%0d want %0d", name, done_cyc, start_cyc + 1);
        end
        total++;
        if (viol !== 0) begin
            bad++;
            $display("FAIL %s outstanding: %0d reads issued beyond 2 outstanding", name, viol);
        end
        if (check_timing) begin
            total++;
            if (first_busy_cyc !== start_cyc + 1 || first_rd_cyc !== start_cyc + 1 ||
                first_val_cyc !== start_cyc + 3) begin
                bad++;
                $display("FAIL %s latency: busy@%0d rd@%0d valid@%0d start@%0d want +1/+1/+3", name,
                         first_busy_cyc, first_rd_cyc, first_val_cyc, start_cyc);
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        total++;
        if ({mem_rd_enable, mem_rd_address, out_valid, out_last, out_data, busy, done} !== '0) begin
            bad++;
            $display("FAIL %s: en=%0b addr=%0h valid=%0b last=%0b data=%0h busy=%0b done=%0b want all 0",
                     name, mem_rd_enable, mem_rd_address, out_valid, out_last, out_data, busy, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        check_idle_outputs("reset_values");
        reset = 1'b0;
        step();
        check_idle_outputs("idle_after_reset");
    endtask

    task automatic test_identity();
        active = 1'b0; tot_blocks = 16'd4; blk_size = 16'd2;
        run_readout("identity", 0, -1, 1'b1);
    endtask

    task automatic test_wrapped();
        do_reset();
        active = 1'b1; tot_blocks = 16'd4; blk_size = 16'd2;
        pulse_update(3);
        run_readout("wrapped", 0, -1, 1'b0);
    endtask

    task automatic test_decode();
`ifdef TCN_FIFO_DECODE_EN
        logic [AW-1:0] ins [3];
        logic [AW-1:0] exp [3];
        ins[0] = 16'd1; exp[0] = 16'd3;
        ins[1] = 16'd7; exp[1] = 16'd1;
        ins[2] = 16'd9; exp[2] = 16'd9;
        for (int i = 0; i < 3; i++) begin
            phys_in = ins[i];
            #1;
            total++;
            if (logical_out !== exp[i]) begin
                bad++;
                $display("FAIL decode phys %0d: got %0d want %0d", ins[i], logical_out, exp[i]);
            end
        end
        phys_in = '0;
`endif
    endtask

    task automatic test_mid_update();
        run_readout("mid_update_run", 0, 2, 1'b0);
        run_readout("after_mid_update", 0, -1, 1'b0);
    endtask

    task automatic test_base_wrap();
        do_reset();
        pulse_update(4);
        run_readout("base_wrap", 0, -1, 1'b0);
    endtask

    task automatic test_backpressure();
        do_reset();
        pulse_update(3);
        run_readout("backpressure_pattern", 1, -1, 1'b0);
        run_readout("backpressure_random", 2, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        active = 1'b1; tot_blocks = 16'd4; blk_size = 16'd2;
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        total++;
        if (mem_rd_enable !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL stall_credit: en=%0b busy=%0b want 0/1", mem_rd_enable, busy);
        end
        reset = 1'b1;
        #1;
        check_idle_outputs("reset_mid_read");
        step();
        reset = 1'b0;
        m_base = 0;
        out_ready = 1'b1;
        step();
        run_readout("after_mid_reset", 0, -1, 1'b0);
    endtask

    task automatic test_empty_window();
        tot_blocks = 16'd0;
        run_readout("empty_window", 0, -1, 1'b0);
        tot_blocks = 16'd4;
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            do_reset();
            active     = 1'($urandom_range(0, 1));
            tot_blocks = 16'($urandom_range(1, 5));
            blk_size   = 16'($urandom_range(1, 4));
            pulse_update(int'($urandom_range(0, 5)));
            run_readout("random", 2, int'($urandom_range(0, 3)), 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1; active = 1'b0; blk_size = '0; tot_blocks = '0;
        update = 1'b0; start = 1'b0; out_ready = 1'b1;
`ifdef TCN_FIFO_DECODE_EN
        phys_in = '0;
`endif
        clear_mon();
        test_reset();
        test_identity();
        test_wrapped();
        test_decode();
        test_mid_update();
        test_base_wrap();
        test_backpressure();
        test_reset_mid();
        test_empty_window();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
